// File: rtl/stuff_pkg.sv
// Shared definitions for the bit-stuffing transmitter: state encodings and defaults.
package stuff_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'b00;
    localparam state_t SEND  = 2'b01;
    localparam state_t STUFF = 2'b10;

    localparam int unsigned RUN_LEN_DEF = 4;

endpackage

// File: rtl/stuff_run_tracker.sv
// Tracks the length of the current run of identical bits on the wire; sole owner of run state.
module stuff_run_tracker
    import stuff_pkg::*;
#(
    parameter int unsigned RUN_LEN = RUN_LEN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic bit_in,
    input  logic bit_en,
    input  logic clr,
    input  logic force_stuff,
    output logic last,
    output logic hit
);

    localparam int unsigned RUN_W = $clog2(RUN_LEN + 1);

    logic [RUN_W-1:0] run_q, run_d;
    logic             last_q, last_d;

    // clr together with bit_en means the emitted bit opens a fresh frame
    always_comb begin
        run_d  = run_q;
        last_d = last_q;
        if (bit_en) begin
            if (clr || (run_q == '0) || (bit_in != last_q)) begin
                run_d = RUN_W'(1);
            end else if (run_q != RUN_W'(RUN_LEN)) begin
                run_d = run_q + RUN_W'(1);
            end
            last_d = bit_in;
        end else if (force_stuff) begin
            run_d  = RUN_W'(1);
            last_d = ~last_q;
        end else if (clr) begin
            run_d  = '0;
            last_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q  <= '0;
            last_q <= 1'b0;
        end else begin
            run_q  <= run_d;
            last_q <= last_d;
        end
    end

    assign last = last_q;
    assign hit  = (run_q == RUN_W'(RUN_LEN));

endmodule

// File: rtl/stuff_tx.sv
// Parallel-to-serial bit-stuffing transmitter, MSB first.
// Optional even-parity trailer enabled by defining STUFF_TX_PARITY_EN.
module stuff_tx
    import stuff_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned RUN_LEN = RUN_LEN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              load,
    output logic              ready,
    output logic              w,
    output logic              w_valid,
    output logic              stuff,
    output logic              busy,
    output logic [1:0]        stout
);

`ifdef STUFF_TX_PARITY_EN
    localparam int unsigned PAR_W = 1;
`else
    localparam int unsigned PAR_W = 0;
`endif
    localparam int unsigned TOT_W = DATA_W + PAR_W;
    localparam int unsigned BL_W  = $clog2(DATA_W + 2);

    state_t           state_q, state_d;
    logic [TOT_W-1:0] shreg_q, shreg_d;
    logic [BL_W-1:0]  bits_left_q, bits_left_d;
    logic             w_q, w_d;
    logic             w_valid_q, w_valid_d;
    logic             stuff_q, stuff_d;
    logic             busy_q, busy_d;

    logic             trk_bit, trk_en, trk_clr, trk_force;
    logic             trk_last, trk_hit;
    logic [TOT_W-1:0] load_val;

`ifdef STUFF_TX_PARITY_EN
    assign load_val = {din, ^din};
`else
    assign load_val = din;
`endif

    stuff_run_tracker #(
        .RUN_LEN(RUN_LEN)
    ) u_run (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (trk_bit),
        .bit_en     (trk_en),
        .clr        (trk_clr),
        .force_stuff(trk_force),
        .last       (trk_last),
        .hit        (trk_hit)
    );

    // state_q names what w is showing this cycle; the next emission is chosen here
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bits_left_d = bits_left_q;
        w_d         = 1'b0;
        w_valid_d   = 1'b0;
        stuff_d     = 1'b0;
        busy_d      = 1'b0;
        trk_bit     = 1'b0;
        trk_en      = 1'b0;
        trk_clr     = 1'b0;
        trk_force   = 1'b0;
        case (state_q)
            IDLE: begin
                trk_clr = 1'b1;
                if (load) begin
                    state_d     = SEND;
                    shreg_d     = {load_val[TOT_W-2:0], 1'b0};
                    bits_left_d = BL_W'(TOT_W - 1);
                    w_d         = load_val[TOT_W-1];
                    w_valid_d   = 1'b1;
                    busy_d      = 1'b1;
                    trk_bit     = load_val[TOT_W-1];
                    trk_en      = 1'b1;
                end
            end
            SEND, STUFF: begin
                if (trk_hit) begin
                    state_d   = STUFF;
                    w_d       = ~trk_last;
                    w_valid_d = 1'b1;
                    stuff_d   = 1'b1;
                    busy_d    = 1'b1;
                    trk_force = 1'b1;
                end else if (bits_left_q != '0) begin
                    state_d     = SEND;
                    shreg_d     = {shreg_q[TOT_W-2:0], 1'b0};
                    bits_left_d = bits_left_q - BL_W'(1);
                    w_d         = shreg_q[TOT_W-1];
                    w_valid_d   = 1'b1;
                    busy_d      = 1'b1;
                    trk_bit     = shreg_q[TOT_W-1];
                    trk_en      = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            bits_left_q <= '0;
            w_q         <= 1'b0;
            w_valid_q   <= 1'b0;
            stuff_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bits_left_q <= bits_left_d;
            w_q         <= w_d;
            w_valid_q   <= w_valid_d;
            stuff_q     <= stuff_d;
            busy_q      <= busy_d;
        end
    end

    assign ready   = (state_q == IDLE);
    assign w       = w_q;
    assign w_valid = w_valid_q;
    assign stuff   = stuff_q;
    assign busy    = busy_q;
    assign stout   = state_q;

endmodule
